// File: rtl/bpsk_burst_ctrl.sv
// BPSK burst sequencer: preamble, payload, FIR tail flush and guard gap.
// Every output is a flop computed from next-state values, so no input reaches an output directly.
module bpsk_burst_ctrl #(
  parameter int unsigned SYM_DIV   = 16,
  parameter int unsigned PRE_LEN   = 32,
  parameter int unsigned FLUSH_CYC = 64,
  parameter int unsigned GAP_CYC   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic        abort,
  input  logic        din,
  output logic        din_req,
  output logic        sym_stb,
  output logic        bit_out,
  output logic        data_en,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPre     = 3'd1,
    StPayload = 3'd2,
    StFlush   = 3'd3,
    StGap     = 3'd4
  } state_e;

  localparam logic [15:0] DivMax   = 16'(SYM_DIV - 1);
  localparam logic [15:0] PreMax   = 16'(PRE_LEN - 1);
  localparam logic [15:0] FlushMax = 16'(FLUSH_CYC - 1);
  localparam logic [15:0] GapMax   = 16'(GAP_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] sym_q, sym_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] len_q, len_d;
  logic        din_req_q, din_req_d;
  logic        sym_stb_q, sym_stb_d;
  logic        bit_out_q, bit_out_d;
  logic        data_en_q, data_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic div_wrap;
  logic in_sym;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sym_d    = sym_q;
    cyc_d    = cyc_q;
    len_d    = len_q;
    div_wrap = (div_q == DivMax);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPre;
          len_d   = len;
          div_d   = '0;
          sym_d   = '0;
        end
      end
      StPre: begin
        if (abort) begin
          state_d = StFlush;
          cyc_d   = '0;
        end else begin
          div_d = div_wrap ? '0 : div_q + 16'd1;
          if (div_wrap) begin
            if (sym_q == PreMax) begin
              sym_d   = '0;
              cyc_d   = '0;
              state_d = (len_q == 16'd0) ? StFlush : StPayload;
            end else begin
              sym_d = sym_q + 16'd1;
            end
          end
        end
      end
      StPayload: begin
        if (abort) begin
          state_d = StFlush;
          cyc_d   = '0;
        end else begin
          div_d = div_wrap ? '0 : div_q + 16'd1;
          if (div_wrap) begin
            if (sym_q == len_q - 16'd1) begin
              state_d = StFlush;
              cyc_d   = '0;
            end else begin
              sym_d = sym_q + 16'd1;
            end
          end
        end
      end
      StFlush: begin
        if (cyc_q == FlushMax) begin
          state_d = StGap;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StGap: begin
        if (cyc_q == GapMax) begin
          state_d = StIdle;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next-cycle state so they line up with it once registered.
  always_comb begin
    in_sym    = (state_d == StPre) || (state_d == StPayload);
    sym_stb_d = in_sym && (div_d == 16'd0);
    data_en_d = in_sym || (state_d == StFlush);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StGap) && (cyc_d == GapMax);

    bit_out_d = 1'b0;
    if (state_d == StPre) begin
      bit_out_d = ~sym_d[0];
    end else if (state_d == StPayload) begin
      bit_out_d = (div_d == 16'd0) ? din : bit_out_q;
    end

    // Request the next payload bit in the final cycle of the symbol before it.
    din_req_d = 1'b0;
    if (div_d == DivMax) begin
      if (state_d == StPre) begin
        din_req_d = (sym_d == PreMax) && (len_d != 16'd0);
      end else if (state_d == StPayload) begin
        din_req_d = (sym_d != len_d - 16'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      sym_q     <= '0;
      cyc_q     <= '0;
      len_q     <= '0;
      din_req_q <= 1'b0;
      sym_stb_q <= 1'b0;
      bit_out_q <= 1'b0;
      data_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sym_q     <= sym_d;
      cyc_q     <= cyc_d;
      len_q     <= len_d;
      din_req_q <= din_req_d;
      sym_stb_q <= sym_stb_d;
      bit_out_q <= bit_out_d;
      data_en_q <= data_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign state   = state_q;
  assign din_req = din_req_q;
  assign sym_stb = sym_stb_q;
  assign bit_out = bit_out_q;
  assign data_en = data_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bpsk_burst_ctrl.sv
// Bench for bpsk_burst_ctrl: table of bursts plus random ones, each cycle compared against a
// timeline model of the burst, followed by reset and back-to-back sequences.
module tb_bpsk_burst_ctrl;

  localparam int SD = 4;
  localparam int PL = 2;
  localparam int FL = 64;
  localparam int GP = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        abort;
  logic        din;
  logic        din_req, sym_stb, bit_out, data_en, busy, done;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  bpsk_burst_ctrl #(
    .SYM_DIV  (SD),
    .PRE_LEN  (PL),
    .FLUSH_CYC(FL),
    .GAP_CYC  (GP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .len    (len),
    .abort  (abort),
    .din    (din),
    .din_req(din_req),
    .sym_stb(sym_stb),
    .bit_out(bit_out),
    .data_en(data_en),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          blen;
    logic [63:0] bits;
    int          abort_at;
    bit          junk;
    bit          abort_idle;
    int          exp_done;
    int          exp_reqs;
  } burst_t;

  burst_t tbl[$];

  function automatic logic [8:0] pack_out();
    return {state, busy, data_en, bit_out, sym_stb, din_req, done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int active_len(input int blen, input int abort_at);
    int nat;
    nat = SD * (PL + blen);
    return (abort_at >= 1 && abort_at <= nat) ? abort_at : nat;
  endfunction

  // Expected outputs at cycle k after start was sampled (k=1 is the first preamble cycle).
  function automatic logic [8:0] model_out(input int k, input int blen, input int abort_at,
                                           input logic [63:0] bits);
    int act, sym, dv;
    logic [2:0] st;
    logic bz, de, bo, ss, dr, dn;
    act = active_len(blen, abort_at);
    st = 3'd0; bz = 0; de = 0; bo = 0; ss = 0; dr = 0; dn = 0;
    if (k >= 1 && k <= act) begin
      sym = (k - 1) / SD;
      dv  = (k - 1) % SD;
      st  = (sym < PL) ? 3'd1 : 3'd2;
      bz  = 1; de = 1;
      ss  = (dv == 0);
      bo  = (sym < PL) ? ((sym % 2) == 0) : bits[sym-PL];
      dr  = (dv == SD - 1) && (sym + 1 >= PL) && (sym + 1 < PL + blen);
    end else if (k > act && k <= act + FL) begin
      st = 3'd3; bz = 1; de = 1;
    end else if (k > act + FL && k <= act + FL + GP) begin
      st = 3'd4; bz = 1;
      dn = (k == act + FL + GP);
    end
    return {st, bz, de, bo, ss, dr, dn};
  endfunction

  task automatic add(input int blen, input logic [63:0] bits, input int abort_at, input bit junk,
                     input bit abort_idle, input int exp_done, input int exp_reqs);
    burst_t b;
    b = '{blen, bits, abort_at, junk, abort_idle, exp_done, exp_reqs};
    tbl.push_back(b);
  endtask

  task automatic run_burst(input burst_t b);
    int act, total, nreq, ndone, done_off;
    act      = active_len(b.blen, b.abort_at);
    total    = act + FL + GP;
    nreq     = 0;
    ndone    = 0;
    done_off = -1;
    check("idle_before", 32'(pack_out()), 32'h0);
    start = 1'b1;
    len   = 16'(b.blen);
    abort = b.abort_idle;
    din   = 1'($urandom);
    for (int k = 1; k <= total + 1; k++) begin
      step();
      check($sformatf("cyc%0d_len%0d", k, b.blen), 32'(pack_out()),
            32'(model_out(k, b.blen, b.abort_at, b.bits)));
      if (done) begin
        ndone++;
        done_off = k;
      end
      start = (b.junk && k < total) ? 1'($urandom) : 1'b0;
      abort = (k == b.abort_at) || (b.junk && k > act && $urandom_range(0, 3) == 0);
      if (din_req) begin
        din = (nreq < 64) ? b.bits[nreq] : 1'b0;
        nreq++;
      end else begin
        din = 1'($urandom);
      end
    end
    abort = 1'b0;
    check("din_req_count", 32'(nreq), 32'(b.exp_reqs));
    check("done_offset", 32'(done_off), 32'(b.exp_done));
    check("done_count", 32'(ndone), 32'd1);
  endtask

  initial begin
    int act, reqs, cnt, ndone;
    bit ok;
    burst_t b;

    rst = 1'b0; start = 1'b0; len = '0; abort = 1'b0; din = 1'b0;
    step();
    step();
    check("reset_state", 32'(pack_out()), 32'h0);
    rst = 1'b1;
    step();
    check("idle_after_reset", 32'(pack_out()), 32'h0);

    add(3, 64'b101, 0, 0, 0, 184, 3);
    add(0, 64'h0, 0, 0, 1, 172, 0);
    add(10, 64'h3A5, 14, 0, 0, 178, 2);
    add(4, 64'b0110, 0, 1, 0, SD * 6 + FL + GP, 4);
    add(1, 64'h1, 5, 0, 0, 5 + FL + GP, 0);
    for (int i = 0; i < 6; i++) begin
      b.blen       = $urandom_range(0, 20);
      b.bits       = {$urandom, $urandom};
      b.abort_at   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, SD * (PL + b.blen)) : 0;
      b.junk       = 1'b1;
      b.abort_idle = 1'($urandom);
      act          = active_len(b.blen, b.abort_at);
      reqs         = 0;
      for (int j = 0; j < b.blen; j++) if (SD * (PL + j) <= act) reqs++;
      b.exp_done   = act + FL + GP;
      b.exp_reqs   = reqs;
      tbl.push_back(b);
    end
    foreach (tbl[i]) run_burst(tbl[i]);

    // Reset mid-payload: outputs clear next cycle, start ignored under reset, no done after.
    start = 1'b1; len = 16'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("pre_reset_payload", 32'(state), 32'd2);
    rst = 1'b0;
    step();
    check("rst_mid_burst", 32'(pack_out()), 32'h0);
    start = 1'b1;
    step();
    check("rst_start_ignored", 32'(pack_out()), 32'h0);
    rst = 1'b1; start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      if (done || busy) ndone++;
    end
    check("no_activity_after_rst", 32'(ndone), 32'd0);

    // Start held high: measure data_en low stretch between two bursts.
    start = 1'b1; len = 16'd1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = data_en; end
    check("b2b_first_start", 32'(ok), 32'd1);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin step(); ok = !data_en; end
    check("b2b_data_en_fall", 32'(ok), 32'd1);
    cnt = 1; ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      if (data_en) ok = 1; else cnt++;
    end
    check("b2b_second_start", 32'(ok), 32'd1);
    check("b2b_gap_cycles", 32'(cnt), 32'(GP + 1));
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin step(); ok = !busy; end
    check("b2b_return_idle", 32'(ok), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bpsk_burst_ctrl.md
BPSK_BURST_CTRL -- requirements
Module: bpsk_burst_ctrl

Interface
REQ-001 Parameter SYM_DIV, default 16: clk cycles per symbol; legal range 2..65535.
REQ-002 Parameter PRE_LEN, default 32: preamble length in symbols; legal range 1..65535.
REQ-003 Parameter FLUSH_CYC, default 64: FIR tail-flush length in clk cycles; legal range 1..65535.
REQ-004 Parameter GAP_CYC, default 100: inter-burst guard length in clk cycles; legal range 1..65535.
REQ-005 clk  in  1  single clock (50 MHz datapath clock); all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  burst request; sampled only in IDLE.
REQ-008 len  in  16  payload length in symbols; captured with start.
REQ-009 abort  in  1  terminate burst early; honoured in PRE and PAYLOAD only.
REQ-010 din  in  1  payload bit; must be valid in the cycle din_req is high.
REQ-011 din_req  out  1  one-cycle pulse requesting the next payload bit.
REQ-012 sym_stb  out  1  one-cycle pulse marking the first cycle of each transmitted symbol.
REQ-013 bit_out  out  1  symbol bit to the FIR mapper (1 -> +1, 0 -> -1).
REQ-014 data_en  out  1  DAC write/clock gate enable.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on burst completion.
REQ-017 state  out  3  encoded state: IDLE=0, PRE=1, PAYLOAD=2, FLUSH=3, GAP=4.

Function
REQ-018 FSM: IDLE -> PRE -> PAYLOAD -> FLUSH -> GAP -> IDLE; no other transitions except REQ-026 and REQ-027.
REQ-019 IDLE: when start=1 in cycle T, capture len; state=PRE from cycle T+1; start in any other state is ignored (not queued).
REQ-020 Symbol timing: a divider counts 0..SYM_DIV-1 and restarts at 0 on entry to PRE; sym_stb=1 whenever divider=0 in PRE or PAYLOAD; each symbol holds bit_out for exactly SYM_DIV cycles.
REQ-021 PRE: bit_out alternates 1,0,1,... starting with 1 in the first PRE cycle; after PRE_LEN symbols go to PAYLOAD, or to FLUSH if captured len=0.
REQ-022 PAYLOAD: din_req=1 in the last cycle of the preceding symbol (divider=SYM_DIV-1); din is sampled in that cycle and drives bit_out from the next cycle (the symbol's first cycle); exactly len din_req pulses per burst.
REQ-023 After the len-th payload symbol completes, go to FLUSH; no din_req is issued after the last payload bit is sampled.
REQ-024 FLUSH: bit_out=0, sym_stb=0, data_en=1 for exactly FLUSH_CYC cycles, then GAP.
REQ-025 GAP: data_en=0, bit_out=0 for exactly GAP_CYC cycles; done=1 in the last GAP cycle; next cycle state=IDLE.
REQ-026 abort=1 in PRE or PAYLOAD: the next cycle enters FLUSH (current symbol truncated); no further din_req is issued; abort in IDLE, FLUSH or GAP has no effect.
REQ-027 Simultaneous abort and natural symbol-end transition: abort wins (go to FLUSH).
REQ-028 data_en=1 in PRE, PAYLOAD and FLUSH; 0 in IDLE and GAP.
REQ-029 All outputs are registered; no combinational path from an input to any output.
REQ-030 Counters are 16-bit and must not wrap within a burst; len=65535 is fully supported.

Reset
REQ-031 rst=0 at a rising edge: state=IDLE; divider and all counters=0; bit_out=0, data_en=0, din_req=0, sym_stb=0, busy=0, done=0.
REQ-032 Reset asserted mid-burst aborts immediately without FLUSH or done; start is ignored while rst=0.

Verification
REQ-033 SYM_DIV=4, PRE_LEN=2, len=3, din=1,0,1 -> bit_out 1x4,0x4,1x4,0x4,1x4, then FLUSH 64 cycles, GAP 100; done at cycle 4*5+64+100 after start; 3 din_req pulses.
REQ-034 len=0 -> PRE directly to FLUSH; zero din_req pulses; done still pulses once.
REQ-035 abort in the 2nd cycle of payload symbol 2 of len=10 -> FLUSH next cycle; only 2 din_req observed; data_en stays high through FLUSH.
REQ-036 start pulsed during PAYLOAD and GAP -> ignored; exactly one done; restart accepted in the IDLE cycle after done.
REQ-037 rst=0 during PAYLOAD -> next cycle all outputs at reset values, state=0, no done.
REQ-038 Back-to-back: start held high continuously -> bursts separated by exactly GAP_CYC data_en-low cycles plus 1 IDLE cycle.
